bwt_inverse: RTL and testbench
==============================

BWT_INVERSE -- requirements
Module: bwt_inverse

Interface
REQ-001 Parameter ELEMENT_NUM, default 8, block length in symbols (power of two, 2..16).
REQ-002 Parameter ELEMENT_LEN, default 8, symbol width in bits.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-low.
REQ-005 Port start  input  1  request to decode the block on data_in/primary_idx.
REQ-006 Port data_in  input  ELEMENT_LEN x [0:ELEMENT_NUM-1]  BWT last column L.
REQ-007 Port primary_idx  input  $clog2(ELEMENT_NUM)  sorted-matrix row holding the original block.
REQ-008 Port busy  output  1  high while a block is being decoded.
REQ-009 Port done  output  1  one-cycle pulse; data_out valid.
REQ-010 Port data_out  output  ELEMENT_LEN x [0:ELEMENT_NUM-1]  reconstructed block, element 0 first.

Function
REQ-011 The block SHALL be the inverse of the sort-based BWT encoder: given L and primary index I, it SHALL output the original block.
REQ-012 FSM states SHALL be IDLE, RANK, WALK, DONE; only IDLE accepts start.
REQ-013 IDLE: start=1 at edge E0 SHALL capture data_in into L buffer and primary_idx into pointer p, set busy=1, go to RANK.
REQ-014 RANK: one row i per cycle, i=0..N-1 (edges E1..EN); T[i] = (count of j with L[j] < L[i]) + (count of j < i with L[j] == L[i]), unsigned compare, T width $clog2(N).
REQ-015 After row N-1, SHALL go to WALK with counter k = N-1.
REQ-016 WALK: each edge (E(N+1)..E(2N)) SHALL write buf[k] = L[p], then p = T[p], k = k-1.
REQ-017 At the edge writing buf[0] (E2N) SHALL copy full buf to data_out, assert done, deassert busy, go to DONE.
REQ-018 Start-to-done latency SHALL be exactly 2N clocks (16 for N=8); done high for exactly one cycle.
REQ-019 DONE SHALL return to IDLE next edge unconditionally; start during DONE SHALL be ignored.
REQ-020 data_out SHALL change only at the done edge, never partially; held until next done or reset.
REQ-021 start while busy SHALL be ignored; captured L and I SHALL NOT change mid-decode.
REQ-022 data_in/primary_idx changes outside the capture edge SHALL have no effect.
REQ-023 Duplicate symbols SHALL be handled by the stable rank term; all-equal L gives T[i]=i.
REQ-024 Back-to-back: start high continuously SHALL begin a new decode on the IDLE edge after DONE (period 2N+2).

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, busy=0, done=0, data_out all zero, and clear L, T, buf, p, k.
REQ-026 Reset mid-decode SHALL abort; no done pulse for the aborted block; after release, decoder waits for a new start.
REQ-027 start sampled on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-028 L={07,00,01,02,03,04,05,06}, I=0, start pulse -> done exactly 16 clocks later, data_out={00,01,02,03,04,05,06,07}.
REQ-029 L={42,42,42,42,41,41,41,41}, I=0 -> data_out={41,42,41,42,41,42,41,42}; T={4,5,6,7,0,1,2,3} internally.
REQ-030 L all 0x55, I=5 -> data_out all 0x55, done after 16 clocks.
REQ-031 start pulses at E3 and E10 of an active decode, data_in changed at E5 -> single done at E16, result of original block only.
REQ-032 rst low at E8 of a decode, released, new start with REQ-028 vector -> no done for aborted block, data_out zero until new done with {00..07}.
REQ-033 Random 8-byte blocks encoded by a reference BWT model (primary index = row of original), start held high -> every result matches original, one done per 18 clocks.

Source files
------------

// File: rtl/bwt_inverse.sv
`default_nettype none
// ============================================================================
// Module   : bwt_inverse
// Brief    : Inverse Burrows-Wheeler transform of one block (LF-mapping walk).
// Revision : 1.0 - initial release
// ============================================================================
module bwt_inverse #(
    parameter int ELEMENT_NUM = 8,
    parameter int ELEMENT_LEN = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ELEMENT_LEN-1:0]         data_in [0:ELEMENT_NUM-1],
    input  logic [$clog2(ELEMENT_NUM)-1:0] primary_idx,
    output logic                           busy,
    output logic                           done,
    output logic [ELEMENT_LEN-1:0]         data_out [0:ELEMENT_NUM-1]
);

    localparam int            IW     = $clog2(ELEMENT_NUM);
    localparam int            CW     = IW + 1;
    localparam logic [IW-1:0] c_LAST = IW'(ELEMENT_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RANK = 2'd1,
        S_WALK = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ELEMENT_LEN-1:0] r_l   [0:ELEMENT_NUM-1];
    logic [IW-1:0]          r_t   [0:ELEMENT_NUM-1];
    logic [ELEMENT_LEN-1:0] r_buf [0:ELEMENT_NUM-1];
    logic [IW-1:0]          r_p;
    logic [IW-1:0]          r_k;
    logic [IW-1:0]          r_row;
    logic [CW-1:0]          w_rank;
    logic [ELEMENT_LEN-1:0] w_sym;

    // Stable rank of L[row]: smaller symbols anywhere plus equal symbols before it.
    always_comb begin
        w_rank = '0;
        for (int j = 0; j < ELEMENT_NUM; j++) begin
            if ((r_l[j] < r_l[r_row]) ||
                ((r_l[j] == r_l[r_row]) && (IW'(j) < r_row))) begin
                w_rank = w_rank + CW'(1);
            end
        end
    end

    assign w_sym = r_l[r_p];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RANK;
                end
            end
            S_RANK: begin
                busy = 1'b1;
                if (r_row == c_LAST) begin
                    w_next = S_WALK;
                end
            end
            S_WALK: begin
                busy = 1'b1;
                if (r_k == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p   <= '0;
            r_k   <= '0;
            r_row <= '0;
            for (int i = 0; i < ELEMENT_NUM; i++) begin
                r_l[i]      <= '0;
                r_t[i]      <= '0;
                r_buf[i]    <= '0;
                data_out[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < ELEMENT_NUM; i++) begin
                            r_l[i] <= data_in[i];
                        end
                        r_p   <= primary_idx;
                        r_row <= '0;
                    end
                end
                S_RANK: begin
                    r_t[r_row] <= w_rank[IW-1:0];
                    r_row      <= r_row + IW'(1);
                    if (r_row == c_LAST) begin
                        r_k <= c_LAST;
                    end
                end
                S_WALK: begin
                    r_buf[r_k] <= w_sym;
                    r_p        <= r_t[r_p];
                    r_k        <= r_k - IW'(1);
                    // Final step publishes the whole block at once, element 0 bypassed.
                    if (r_k == '0) begin
                        data_out[0] <= w_sym;
                        for (int i = 1; i < ELEMENT_NUM; i++) begin
                            data_out[i] <= r_buf[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bwt_inverse.sv
`default_nettype none
// Testbench for bwt_inverse: directed vector table, corner sequences and
// back-to-back blocks produced by a rotation-sorting BWT encoder.
module tb_bwt_inverse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in  [0:7];
    logic [2:0] primary_idx = '0;
    logic       busy;
    logic       done;
    logic [7:0] data_out [0:7];

    int errors = 0;
    int checks = 0;

    bwt_inverse #(.ELEMENT_NUM(8), .ELEMENT_LEN(8)) dut (
        .clk(clk), .rst(rst_n), .start(start), .data_in(data_in),
        .primary_idx(primary_idx), .busy(busy), .done(done), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] l;
        logic [2:0]  idx;
        logic [63:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [63:0] v);
        for (int i = 0; i < 8; i++) data_in[i] = v[63-8*i -: 8];
    endtask

    function automatic logic [63:0] get_out();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[63-8*i -: 8] = data_out[i];
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] sym(input logic [63:0] s, input int i);
        return s[63-8*(i%8) -: 8];
    endfunction

    function automatic bit rot_less(input logic [63:0] s, input int a, input int b);
        for (int k = 0; k < 8; k++) begin
            if (sym(s, a+k) != sym(s, b+k)) return sym(s, a+k) < sym(s, b+k);
        end
        return 1'b0;
    endfunction

    // Forward BWT: sort all rotations, take last column, locate the original row.
    task automatic bwt_encode(input logic [63:0] s, output logic [63:0] l, output logic [2:0] idx);
        int ord [8];
        int t;
        for (int i = 0; i < 8; i++) ord[i] = i;
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 8; j++)
                if (rot_less(s, ord[j], ord[i])) begin
                    t = ord[i]; ord[i] = ord[j]; ord[j] = t;
                end
        idx = '0;
        for (int r = 0; r < 8; r++) begin
            l[63-8*r -: 8] = sym(s, ord[r] + 7);
            if (ord[r] == 0) idx = 3'(r);
        end
    endtask

    task automatic run_block(input string nm, input logic [63:0] l, input logic [2:0] idx,
                             input logic [63:0] exp);
        logic [63:0] prev;
        int n;
        bit got, stable;
        prev = get_out();
        set_in(l);
        primary_idx = idx;
        start = 1'b1;
        step();
        start = 1'b0;
        check({nm, " busy"}, 64'(busy), 64'd1);
        n = 0; got = 0; stable = 1;
        while (!got && n < 40) begin
            step();
            n++;
            if (done) got = 1;
            else if (get_out() !== prev) stable = 0;
        end
        check({nm, " latency"}, 64'(n), 64'd16);
        check({nm, " data"}, get_out(), exp);
        check({nm, " busy at done"}, 64'(busy), 64'd0);
        check({nm, " out held"}, 64'(stable), 64'd1);
        step();
        check({nm, " done width"}, 64'(done), 64'd0);
    endtask

    vec_t tbl [4];

    initial begin
        logic [63:0] orig [6];
        logic [63:0] enc;
        logic [2:0]  eidx;
        int n, ndone, dedge;
        bit got;

        tbl[0] = '{l: 64'h07_00_01_02_03_04_05_06, idx: 3'd0, exp: 64'h00_01_02_03_04_05_06_07};
        tbl[1] = '{l: 64'h42_42_42_42_41_41_41_41, idx: 3'd0, exp: 64'h41_42_41_42_41_42_41_42};
        tbl[2] = '{l: 64'h55_55_55_55_55_55_55_55, idx: 3'd5, exp: 64'h55_55_55_55_55_55_55_55};
        tbl[3] = '{l: 64'h01_00_00_00_01_00_00_00, idx: 3'd7, exp: 64'h01_00_01_00_00_00_00_00};
        set_in('0);

        #12;
        check("reset data_out", get_out(), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // First edge after reset release accepts start.
        for (int v = 0; v < 4; v++)
            run_block($sformatf("vec%0d", v), tbl[v].l, tbl[v].idx, tbl[v].exp);

        // Extra starts and input changes during a decode are ignored.
        set_in(tbl[1].l);
        primary_idx = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0; dedge = 0;
        for (int e = 1; e <= 20; e++) begin
            start = (e == 3 || e == 10);
            if (e == 5) begin
                set_in(64'h10_20_30_40_50_60_70_80);
                primary_idx = 3'd3;
            end
            step();
            if (done) begin
                ndone++;
                dedge = e;
            end
        end
        start = 1'b0;
        check("ignore done count", 64'(ndone), 64'd1);
        check("ignore done edge", 64'(dedge), 64'd16);
        check("ignore data", get_out(), tbl[1].exp);

        // Reset mid-decode aborts and clears the output.
        set_in(tbl[2].l);
        primary_idx = 3'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) step();
        rst_n = 1'b0;
        #1;
        check("abort data_out", get_out(), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int e = 0; e < 3; e++) begin
            step();
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            if (done) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);
        check("abort idle busy", 64'(busy), 64'd0);
        run_block("post reset", tbl[0].l, tbl[0].idx, tbl[0].exp);

        // Back-to-back random blocks with start held high.
        for (int b = 0; b < 6; b++) orig[b] = {$urandom, $urandom};
        orig[0][31:0] = orig[0][63:32];
        bwt_encode(orig[0], enc, eidx);
        set_in(enc);
        primary_idx = eidx;
        start = 1'b1;
        step();
        for (int b = 0; b < 6; b++) begin
            n = 0; got = 0;
            while (!got && n < 40) begin
                step();
                n++;
                if (done) got = 1;
            end
            check($sformatf("b2b%0d period", b), 64'(n), (b == 0) ? 64'd16 : 64'd18);
            check($sformatf("b2b%0d data", b), get_out(), orig[b]);
            if (b < 5) begin
                bwt_encode(orig[b+1], enc, eidx);
                set_in(enc);
                primary_idx = eidx;
            end
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
